// File: rtl/cam_ram_partitioned_dyn.sv
// -----------------------------------------------------------------------------
// cam_ram_partitioned_dyn
//
// Partitioned CAM/RAM whose partitions can be power-gated at runtime. Each of
// NUM_PARTS partitions owns DEPTH/NUM_PARTS consecutive entries and runs its
// own OFF -> INIT -> ON state machine. On un-gating, a partition rewrites its
// entries with the reset pattern (one entry per cycle). Only then does it
// report ready and expose its contents to reads and CAM searches.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   reset             synchronous, active-low reset
//   partitionGated_i  [NUM_PARTS]           1 = partition requested off
//   tag_i             [NUM_CAM_RD_PORTS*W]  CAM search tags
//   vect_o            [NUM_CAM_RD_PORTS*D]  match vectors, bit k = entry k
//   addr_i            [NUM_RAM_RD_PORTS*I]  RAM read addresses
//   data_o            [NUM_RAM_RD_PORTS*W]  RAM read data (0 if not ON)
//   addrWr_i          [NUM_WR_PORTS*I]      write addresses
//   dataWr_i          [NUM_WR_PORTS*W]      write data
//   wrEn_i            [NUM_WR_PORTS]        write enables
//   partReady_o       [NUM_PARTS]           partition is ON
//   ramReady_o        every partition that is not gated is ON
//   wrDropErr_o       sticky: a write hit a partition that was not ON
//
// Build option
//   CAM_RAM_RD_REG_EN  when defined, vect_o and data_o are registered
//                      (1-cycle read latency). The default is combinational.
// -----------------------------------------------------------------------------

`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module cam_ram_partitioned_dyn #(
    parameter int DEPTH            = 32,
    parameter int INDEX            = 5,
    parameter int WIDTH            = 8,
    parameter int FUNCTION         = 0,
    parameter int NUM_WR_PORTS     = 2,
    parameter int NUM_CAM_RD_PORTS = 2,
    parameter int NUM_RAM_RD_PORTS = 2,
    parameter int NUM_PARTS        = 4,
    parameter int NUM_PARTS_LOG    = 2,
    parameter int RESET_VAL        = `RAM_RESET_ZERO,
    parameter int SEQ_START        = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PARTS-1:0]              partitionGated_i,
    input  logic [NUM_CAM_RD_PORTS*WIDTH-1:0] tag_i,
    output logic [NUM_CAM_RD_PORTS*DEPTH-1:0] vect_o,
    input  logic [NUM_RAM_RD_PORTS*INDEX-1:0] addr_i,
    output logic [NUM_RAM_RD_PORTS*WIDTH-1:0] data_o,
    input  logic [NUM_WR_PORTS*INDEX-1:0]     addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]     dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]           wrEn_i,
    output logic [NUM_PARTS-1:0]              partReady_o,
    output logic                              ramReady_o,
    output logic                              wrDropErr_o
);

    localparam int P  = DEPTH / NUM_PARTS;      // entries per partition
    localparam int LW = INDEX - NUM_PARTS_LOG;  // local index width

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_INIT = 2'd1,
        S_ON   = 2'd2
    } state_t;

    // Storage. No reset: an OFF partition's contents are never exposed and
    // INIT rewrites every entry before the partition turns ON.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [NUM_PARTS-1:0]       part_on;
    logic [NUM_PARTS-1:0]       init_next;     // next state is INIT (no reset)
    logic [NUM_PARTS-1:0]       init_we;
    logic [NUM_PARTS-1:0]       visible;
    logic [NUM_PARTS*INDEX-1:0] init_addr;
    logic [NUM_PARTS*WIDTH-1:0] init_data;

    logic [NUM_WR_PORTS-1:0]    wr_ok;
    logic [NUM_WR_PORTS-1:0]    wr_drop;

    logic                       ram_ready_reg;
    logic                       drop_err_reg;

    logic [NUM_CAM_RD_PORTS*DEPTH-1:0] vect_comb;
    logic [NUM_RAM_RD_PORTS*WIDTH-1:0] data_comb;

    // -------------------------------------------------------------------------
    // Per-partition power/init state machines
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PARTS; gi++) begin : g_part
            state_t         state_reg, state_next;
            logic [LW-1:0]  cnt_reg, cnt_next;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                unique case (state_reg)
                    S_OFF: begin
                        if (!partitionGated_i[gi]) begin
                            state_next = S_INIT;
                            cnt_next   = '0;
                        end
                    end
                    S_INIT: begin
                        if (partitionGated_i[gi]) begin
                            state_next = S_OFF;
                        end else if (cnt_reg == LW'(P - 1)) begin
                            state_next = S_ON;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    S_ON: begin
                        if (partitionGated_i[gi]) begin
                            state_next = S_OFF;
                        end
                    end
                    default: state_next = S_OFF;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    state_reg <= partitionGated_i[gi] ? S_OFF : S_INIT;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign part_on[gi]   = (state_reg == S_ON);
            assign init_next[gi] = (state_next == S_INIT);
            // An init write in the cycle the partition is being gated is
            // pointless; the contents become undefined anyway.
            assign init_we[gi]   = reset && (state_reg == S_INIT) && !partitionGated_i[gi];
            // A partition being gated is hidden already in the cycle the
            // request is raised, not one cycle later when it reaches OFF.
            assign visible[gi]   = part_on[gi] && !partitionGated_i[gi];
            assign init_addr[gi*INDEX +: INDEX] = {NUM_PARTS_LOG'(gi), cnt_reg};

            if (RESET_VAL == `RAM_RESET_SEQ) begin : g_seq
                assign init_data[gi*WIDTH +: WIDTH] =
                    WIDTH'(SEQ_START + gi * P + int'(cnt_reg));
            end else begin : g_zero
                assign init_data[gi*WIDTH +: WIDTH] = '0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Write-port qualification against the target partition's state
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_wr
            logic [NUM_PARTS_LOG-1:0] wr_part;
            assign wr_part     = addrWr_i[gi*INDEX + INDEX - 1 -: NUM_PARTS_LOG];
            assign wr_ok[gi]   = reset && wrEn_i[gi] &&  part_on[wr_part];
            assign wr_drop[gi] = reset && wrEn_i[gi] && !part_on[wr_part];
        end
    endgenerate

    // Init writes and user writes never collide: user writes only land in ON
    // partitions, init writes only in INIT ones. Ports are applied in
    // ascending order so the highest-numbered port wins a same-entry clash.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (init_we[p]) begin
                mem[init_addr[p*INDEX +: INDEX]] <= init_data[p*WIDTH +: WIDTH];
            end
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_ok[w]) begin
                mem[addrWr_i[w*INDEX +: INDEX]] <= dataWr_i[w*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_err_reg <= 1'b0;
        end else if (|wr_drop) begin
            drop_err_reg <= 1'b1;
        end
    end

    // Registered from next-state so it changes on the same edge as the
    // partition states; a partition counts as settled when OFF or ON.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_ready_reg <= &partitionGated_i;
        end else begin
            ram_ready_reg <= ~|init_next;
        end
    end

    // -------------------------------------------------------------------------
    // CAM search
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_CAM_RD_PORTS; gi++) begin : g_cam
            for (gj = 0; gj < DEPTH; gj++) begin : g_ent
                logic hit;
                if (FUNCTION == 0) begin : g_eq
                    assign hit = (mem[gj] == tag_i[gi*WIDTH +: WIDTH]);
                end else begin : g_gt
                    assign hit = (mem[gj] > tag_i[gi*WIDTH +: WIDTH]);
                end
                assign vect_comb[gi*DEPTH + gj] = visible[gj / P] && hit;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // RAM read
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RAM_RD_PORTS; gi++) begin : g_rd
            logic [INDEX-1:0]         rd_addr;
            logic [NUM_PARTS_LOG-1:0] rd_part;
            assign rd_addr = addr_i[gi*INDEX +: INDEX];
            assign rd_part = rd_addr[INDEX-1 -: NUM_PARTS_LOG];
            assign data_comb[gi*WIDTH +: WIDTH] = visible[rd_part] ? mem[rd_addr] : '0;
        end
    endgenerate

`ifdef CAM_RAM_RD_REG_EN
    logic [NUM_CAM_RD_PORTS*DEPTH-1:0] vect_reg;
    logic [NUM_RAM_RD_PORTS*WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vect_reg <= '0;
            data_reg <= '0;
        end else begin
            vect_reg <= vect_comb;
            data_reg <= data_comb;
        end
    end

    assign vect_o = vect_reg;
    assign data_o = data_reg;
`else
    assign vect_o = vect_comb;
    assign data_o = data_comb;
`endif

    assign partReady_o = part_on;
    assign ramReady_o  = ram_ready_reg;
    assign wrDropErr_o = drop_err_reg;

endmodule

// File: tb/tb_cam_ram_partitioned_dyn.sv
// -----------------------------------------------------------------------------
// Bench for cam_ram_partitioned_dyn (default combinational-read build,
// SEQ init pattern, 32 entries in 4 partitions of 8).
// -----------------------------------------------------------------------------
module tb_cam_ram_partitioned_dyn;

    localparam int DEPTH = 32;
    localparam int P     = 8;
    localparam int NP    = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  gated;
    logic [15:0] tag;
    logic [63:0] vect;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [9:0]  addr_wr;
    logic [15:0] data_wr;
    logic [1:0]  wr_en;
    logic [3:0]  part_rdy;
    logic        ram_rdy;
    logic        drop_err;

    cam_ram_partitioned_dyn #(
        .DEPTH(32), .INDEX(5), .WIDTH(8), .FUNCTION(0),
        .NUM_WR_PORTS(2), .NUM_CAM_RD_PORTS(2), .NUM_RAM_RD_PORTS(2),
        .NUM_PARTS(4), .NUM_PARTS_LOG(2), .RESET_VAL(1), .SEQ_START(0)
    ) dut (
        .clk(clk),
        .reset(rst),
        .partitionGated_i(gated),
        .tag_i(tag),
        .vect_o(vect),
        .addr_i(addr),
        .data_o(data),
        .addrWr_i(addr_wr),
        .dataWr_i(data_wr),
        .wrEn_i(wr_en),
        .partReady_o(part_rdy),
        .ramReady_o(ram_rdy),
        .wrDropErr_o(drop_err)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 = off, 1 = initialising, 2 = ready
    int         mode [NP];
    int         progress [NP];   // init cycles completed so far
    logic [7:0] mmem [DEPTH];
    bit         merr;
    bit         chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int a;
        int p;
        if (!rst) begin
            for (int q = 0; q < NP; q++) begin
                mode[q]     = gated[q] ? 0 : 1;
                progress[q] = 0;
            end
            merr = 1'b0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w]) begin
                    a = int'(addr_wr[w*5 +: 5]);
                    p = a / P;
                    if (mode[p] == 2) mmem[a] = data_wr[w*8 +: 8];
                    else              merr    = 1'b1;
                end
            end
            for (int q = 0; q < NP; q++) begin
                if (mode[q] == 0) begin
                    if (!gated[q]) begin
                        mode[q]     = 1;
                        progress[q] = 0;
                    end
                end else if (mode[q] == 1) begin
                    if (gated[q]) begin
                        mode[q] = 0;
                    end else begin
                        progress[q]++;
                        if (progress[q] == P) begin
                            mode[q] = 2;
                            for (int i = 0; i < P; i++) mmem[q*P + i] = 8'(q*P + i);
                        end
                    end
                end else if (gated[q]) begin
                    mode[q] = 0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [63:0] ev;
        logic [63:0] ed;
        logic [63:0] er;
        logic        all_settled;
        bit          vis [NP];
        int          ra;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                for (int q = 0; q < NP; q++) vis[q] = (mode[q] == 2) && !gated[q];
                ev = '0;
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < DEPTH; k++)
                        ev[c*DEPTH + k] = vis[k / P] && (mmem[k] == tag[c*8 +: 8]);
                ed = '0;
                for (int r = 0; r < 2; r++) begin
                    ra = int'(addr[r*5 +: 5]);
                    ed[r*8 +: 8] = vis[ra / P] ? mmem[ra] : 8'h00;
                end
                er = '0;
                all_settled = 1'b1;
                for (int q = 0; q < NP; q++) begin
                    er[q] = (mode[q] == 2);
                    if (mode[q] == 1) all_settled = 1'b0;
                end
                chk("vect", vect, ev);
                chk("data", {48'd0, data}, ed);
                chk("part_ready", {60'd0, part_rdy}, er);
                chk("ram_ready", {63'd0, ram_rdy}, {63'd0, all_settled});
                chk("drop_err", {63'd0, drop_err}, {63'd0, merr});
            end
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        rst = 1'b0; gated = 4'h0; tag = '0; addr = '0;
        addr_wr = '0; data_wr = '0; wr_en = '0;

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b1;                        // reset held low for one edge
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #3;
            if (i == 7) chk("lit_rdy_before", {60'd0, part_rdy}, 64'h0);
            if (i == 8) chk("lit_rdy_after_reset", {60'd0, part_rdy}, 64'hF);
        end

        // SEQ contents
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            addr = {5'(31 - a), 5'(a)};
            #3;
            chk("lit_seq_p0", {56'd0, data[7:0]},  64'(a));
            chk("lit_seq_p1", {56'd0, data[15:8]}, 64'(31 - a));
        end

        // CAM match after write via port 1
        @(negedge clk);
        wr_en = 2'b10; addr_wr = {5'd13, 5'd0}; data_wr = {8'hA5, 8'h00};
        @(negedge clk);
        wr_en = 2'b00; tag = {8'd13, 8'hA5};
        #3;
        chk("lit_cam_a5", {32'd0, vect[31:0]}, 64'h0000_2000);
        chk("lit_cam_13", {32'd0, vect[63:32]}, 64'h0);

        // Port conflict
        @(negedge clk);
        wr_en = 2'b11; addr_wr = {5'd5, 5'd5}; data_wr = {8'h22, 8'h11};
        @(negedge clk);
        wr_en = 2'b00; addr = {5'd0, 5'd5};
        #3;
        chk("lit_conflict", {56'd0, data[7:0]}, 64'h22);

        // Gate partition 2
        @(negedge clk);
        tag = {8'd0, 8'd20}; addr = {5'd0, 5'd17};
        #3;
        chk("lit_pre_gate_cam", {32'd0, vect[31:0]}, 64'h0010_0000);
        chk("lit_pre_gate_rd", {56'd0, data[7:0]}, 64'd17);
        @(negedge clk);
        gated = 4'b0100;
        #3;
        chk("lit_gate_cam", {32'd0, vect[31:0]}, 64'h0);
        chk("lit_gate_rd", {56'd0, data[7:0]}, 64'h0);
        @(negedge clk);
        #3;
        chk("lit_gate_rdy", {60'd0, part_rdy}, 64'hB);
        repeat (2) @(negedge clk);

        // Ungate, drop a write during INIT
        gated = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wr_en = 2'b01; addr_wr = {5'd0, 5'd20}; data_wr = {8'h00, 8'hFF};
            end else begin
                wr_en = 2'b00;
            end
            #3;
            if (k == 2) chk("lit_drop_err", {63'd0, drop_err}, 64'h1);
            if (k == 8) chk("lit_ungate_rdy8", {60'd0, part_rdy}, 64'hB);
            if (k == 9) chk("lit_ungate_rdy9", {60'd0, part_rdy}, 64'hF);
        end
        @(negedge clk);
        addr = {5'd20, 5'd17};
        #3;
        chk("lit_reinit_17", {56'd0, data[7:0]}, 64'd17);
        chk("lit_reinit_20", {56'd0, data[15:8]}, 64'd20);
        chk("lit_err_sticky", {63'd0, drop_err}, 64'h1);

        // Reset during the 4th INIT cycle of partition 1
        @(negedge clk);
        gated = 4'b0010;
        @(negedge clk);
        gated = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #3;
            if (k == 4) chk("lit_mid_init_rdy", {60'd0, part_rdy}, 64'hD);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            #3;
            if (j == 1) chk("lit_err_cleared", {63'd0, drop_err}, 64'h0);
            if (j == 7) chk("lit_rst_rdy7", {60'd0, part_rdy}, 64'h0);
            if (j == 8) chk("lit_rst_rdy8", {60'd0, part_rdy}, 64'hF);
        end
        @(negedge clk);
        addr = {5'd5, 5'd13};
        #3;
        chk("lit_rst_13", {56'd0, data[7:0]}, 64'd13);
        chk("lit_rst_5", {56'd0, data[15:8]}, 64'd5);

        // Randomised traffic checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) gated[$urandom_range(0, 3)] ^= 1'b1;
            wr_en   = 2'($urandom);
            addr_wr = 10'($urandom);
            for (int w = 0; w < 2; w++)
                data_wr[w*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            for (int c = 0; c < 2; c++)
                tag[c*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            addr = 10'($urandom);
        end

        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_ram_partitioned_dyn.md
# cam_ram_partitioned_dyn

Partitioned CAM/RAM with per-partition power-gating control and self-initialisation. Each of NUM_PARTS partitions holds DEPTH/NUM_PARTS entries and has its own OFF/INIT/ON state machine. When a partition is un-gated, it rewrites its contents to the reset pattern one entry per cycle, then reports ready. It sits under the issue-queue and load/store wakeup structures, where partitions are gated by the dynamic-resizing controller, and replaces static partitioned CAM/RAM instances wherever runtime resizing is required.

## Interface
- DEPTH, 32: total entries; must be a multiple of NUM_PARTS.
- INDEX, 5: log2(DEPTH).
- WIDTH, 8: entry width.
- FUNCTION, 0: CAM compare; 0 = equal-to, 1 = greater-than (stored > tag, unsigned).
- NUM_WR_PORTS, 2; NUM_CAM_RD_PORTS, 2; NUM_RAM_RD_PORTS, 2.
- NUM_PARTS, 4; NUM_PARTS_LOG, 2.
- RESET_VAL, `RAM_RESET_ZERO: init pattern, ZERO or SEQ.
- SEQ_START, 0: SEQ pattern base.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  **synchronous, active-low** (low at a clk edge resets).
- partitionGated_i  in  NUM_PARTS  1 = partition requested off.
- tag_i  in  NUM_CAM_RD_PORTS×WIDTH  CAM search tags.
- vect_o  out  NUM_CAM_RD_PORTS×DEPTH  match vectors; bit k is global entry k.
- addr_i  in  NUM_RAM_RD_PORTS×INDEX  RAM read addresses.
- data_o  out  NUM_RAM_RD_PORTS×WIDTH  RAM read data.
- addrWr_i  in  NUM_WR_PORTS×INDEX  write addresses.
- dataWr_i  in  NUM_WR_PORTS×WIDTH  write data.
- wrEn_i  in  NUM_WR_PORTS  write enables.
- partReady_o  out  NUM_PARTS  partition in ON state.
- ramReady_o  out  1  every partition that is not gated is ON.
- wrDropErr_o  out  1  sticky; a write targeted a partition that was not ON.

## Operation
- Addressing: P = DEPTH/NUM_PARTS. Partition = addr[INDEX-1 -: NUM_PARTS_LOG]; local index = low INDEX-NUM_PARTS_LOG bits.
- Per-partition FSM:
  - OFF → INIT when partitionGated_i[p] = 0. The init counter is loaded with 0.
  - INIT writes entry cnt each cycle, then increments cnt. After writing entry P-1, the next state is ON.
  - ON → OFF when partitionGated_i[p] = 1.
  - INIT → OFF when gated mid-init; the counter is discarded.
- Init value: ZERO gives 0. SEQ gives (SEQ_START + p*P + i) truncated to WIDTH.
- Writes:
  - A write is accepted only if the target partition is ON.
  - If the target partition is OFF or INIT, the write is dropped and wrDropErr_o is set. wrDropErr_o clears only on reset.
  - When several ports hit the same entry in the same cycle, the highest-numbered port wins.
- CAM:
  - vect_o bits of a partition are forced to 0 unless that partition is ON.
  - Stored contents of an OFF partition are undefined; they are never exposed.
- RAM read: data_o = selected entry if its partition is ON, else 0.
- Reset (reset low at an edge):
  - Every FSM goes to INIT with cnt = 0 if partitionGated_i[p] = 0, else OFF.
  - wrDropErr_o clears. Reset mid-INIT or mid-ON restarts initialisation.

## Timing
- Reset values: partReady_o = 0, ramReady_o = 0 (1 if all partitions are gated), wrDropErr_o = 0.
  - vect_o and data_o are 0 (registered-read build) or follow the combinational rules above.
- Un-gate to ready: partitionGated_i falls at edge t; INIT is entered at t+1; partReady_o rises at t+1+P.
- Gate: partitionGated_i rises before edge t; partReady_o falls after t. Outputs of that partition are masked from the same cycle.
- Write accepted at edge t is visible to CAM and RAM reads in cycle t+1 (no bypass).
- ramReady_o is registered and aligned with partReady_o.

## Configuration
- CAM_RAM_RD_REG_EN defined: vect_o and data_o are registered, giving 1 cycle read latency.
  - Masking uses the partition state at the sampling edge.
  - A write at edge t is visible in output at t+2.
- Not defined: reads are combinational from inputs and stored state.

## Test plan
- **Reset init.** Parameters DEPTH=32, P=8, SEQ, SEQ_START=0, none gated. Hold reset low 1 cycle.
  - partReady_o = 4'b1111 exactly 8 cycles after release.
  - RAM reads of addr 0..31 return 0..31.
- **CAM match.** Write 8'hA5 to addr 13 via port 1.
  - Next cycle tag 8'hA5 gives vect_o[port] = 32'h0000_2000, plus any SEQ entries equal to 0xA5 (none).
- **Gate/ungate.** Gate partition 2 at cycle 20.
  - vect_o bits 23:16 = 0 and data_o for addr 17 = 0 immediately.
  - Ungate at 30: partReady_o[2] rises at 39, and addr 17 reads 17.
- **Dropped write.** Write to addr 20 while partition 2 is in INIT.
  - wrDropErr_o = 1 next cycle and stays set.
  - After INIT, addr 20 reads 20.
- **Port conflict.** Ports 0 and 1 both write addr 5 (0x11, 0x22) in the same cycle. addr 5 reads 0x22.
- **Reset mid-INIT.** Assert reset during the 4th INIT cycle.
  - Counters restart, and ready comes 8 cycles after release.
